pc_sequencer: RTL and testbench

- Multi-cycle controller that owns the program counter register and sequences instruction fetch for the MIPS core.
- Issues fetch requests to instruction memory with a ready handshake, and holds the PC while the datapath executes.
- On datapath commit, selects the next PC: sequential, branch, jump, jump-register or exception vector.
- Sits between the datapath control unit and the instruction-memory port.

---
 rtl/pc_sequencer_if.sv | 61 ++++++
 rtl/pc_sequencer.sv | 120 ++++++++++++
 tb/tb_pc_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Fetch/commit bundle between the PC sequencer, the datapath
// control unit and the instruction-memory port.
interface pc_sequencer_if;
  logic        imem_ready;
  logic        stall;
  logic        commit;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic        jr;
  logic [31:0] jr_target;
  logic        exception;
  logic        halt;
  logic [31:0] pc_out;
  logic        imem_req;
  logic        instr_valid;
  logic [31:0] epc;
  logic        misalign;
  logic        halted;

  modport master (
    output imem_ready,
    output stall,
    output commit,
    output branch_taken,
    output branch_target,
    output jump,
    output jump_target,
    output jr,
    output jr_target,
    output exception,
    output halt,
    input  pc_out,
    input  imem_req,
    input  instr_valid,
    input  epc,
    input  misalign,
    input  halted
  );

  modport slave (
    input  imem_ready,
    input  stall,
    input  commit,
    input  branch_taken,
    input  branch_target,
    input  jump,
    input  jump_target,
    input  jr,
    input  jr_target,
    input  exception,
    input  halt,
    output pc_out,
    output imem_req,
    output instr_valid,
    output epc,
    output misalign,
    output halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle PC owner: fetch handshake, hold during execute,
// next-PC selection on commit with exception/misalign redirect.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
  input  logic              clk,
  input  logic              reset,
  pc_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic        req_q, req_d;
  logic        iv_q, iv_d;
  logic        mis_q, mis_d;
  logic        hlt_q, hlt_d;

  logic [31:0] tgt;
  logic        redir;
  logic        bad_tgt;
  logic        accept;

  always_comb begin
    tgt   = pc_q + 32'd4;
    redir = 1'b1;
    priority case (1'b1)
      bus.jr:           tgt = bus.jr_target;
      bus.jump:         tgt = bus.jump_target;
      bus.branch_taken: tgt = bus.branch_target;
      default:          redir = 1'b0;
    endcase
  end

  assign bad_tgt = redir && (tgt[1:0] != 2'b00);
  assign accept  = bus.commit && !bus.stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    epc_d   = epc_q;
    req_d   = 1'b0;
    iv_d    = 1'b0;
    mis_d   = mis_q;
    hlt_d   = hlt_q;
    unique case (state_q)
      FETCH: begin
        // ready only counts once the request is visible
        if (req_q && bus.imem_ready) begin
          state_d = EXEC;
          iv_d    = 1'b1;
        end else begin
          req_d = 1'b1;
        end
      end
      EXEC: begin
        if (accept) begin
          state_d = FETCH;
          req_d   = 1'b1;
          if (bus.exception) begin
            epc_d = pc_q;
            pc_d  = EXC_VECTOR;
            mis_d = 1'b0;
          end else if (bus.halt) begin
            state_d = HALT;
            req_d   = 1'b0;
            hlt_d   = 1'b1;
          end else if (bad_tgt) begin
            epc_d = pc_q;
            pc_d  = EXC_VECTOR;
            mis_d = 1'b1;
          end else begin
            pc_d = tgt;
          end
        end
      end
      HALT: begin
        hlt_d = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_VECTOR;
      epc_q   <= 32'h0;
      req_q   <= 1'b0;
      iv_q    <= 1'b0;
      mis_q   <= 1'b0;
      hlt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      req_q   <= req_d;
      iv_q    <= iv_d;
      mis_q   <= mis_d;
      hlt_q   <= hlt_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.imem_req    = req_q;
  assign bus.instr_valid = iv_q;
  assign bus.epc         = epc_q;
  assign bus.misalign    = mis_q;
  assign bus.halted      = hlt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table,
// hand-written corner sequences, then random traffic vs a model.
module tb_pc_sequencer;

  localparam logic [31:0] EXCV = 32'h8000_0180;
  localparam logic [4:0] C_EXC = 5'b10000;
  localparam logic [4:0] C_HLT = 5'b01000;
  localparam logic [4:0] C_JR  = 5'b00100;
  localparam logic [4:0] C_JMP = 5'b00010;
  localparam logic [4:0] C_BR  = 5'b00001;

  localparam int PF = 0;
  localparam int PE = 1;
  localparam int PH = 2;

  logic clk = 1'b0;
  logic reset;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR(32'h0000_0000),
    .EXC_VECTOR  (32'h8000_0180)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        cmt;
    logic        stl;
    logic [4:0]  ctl;
    logic [31:0] bt;
    logic [31:0] pc;
    logic        req;
    logic        iv;
    logic [31:0] epc;
    logic        mis;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];
  int   tests = 0;
  int   fails = 0;

  int          m_ph;
  logic [31:0] m_pc;
  logic [31:0] m_epc;
  logic        m_mis;
  logic        m_hlt;
  logic        m_req;
  logic        m_iv;

  task automatic add(
    input logic rst, input logic rdy,
    input logic cmt, input logic stl,
    input logic [4:0] ctl, input logic [31:0] bt,
    input logic [31:0] pc, input logic req,
    input logic iv, input logic [31:0] epc,
    input logic mis, input logic hlt);
    vec_t v;
    v.rst = rst; v.rdy = rdy;
    v.cmt = cmt; v.stl = stl;
    v.ctl = ctl; v.bt  = bt;
    v.pc  = pc;  v.req = req;
    v.iv  = iv;  v.epc = epc;
    v.mis = mis; v.hlt = hlt;
    tbl.push_back(v);
  endtask

  task automatic drive(
    input logic rst, input logic rdy,
    input logic cmt, input logic stl,
    input logic [4:0] ctl, input logic [31:0] bt);
    reset            = rst;
    bus.imem_ready   = rdy;
    bus.commit       = cmt;
    bus.stall        = stl;
    bus.exception    = ctl[4];
    bus.halt         = ctl[3];
    bus.jr           = ctl[2];
    bus.jump         = ctl[1];
    bus.branch_taken = ctl[0];
    bus.branch_target = bt;
  endtask

  // Next-PC rules written directly from the architectural behaviour
  task automatic model_step();
    logic [31:0] nxt;
    bit          redir;
    if (!reset) begin
      m_ph = PF; m_pc = 32'h0; m_epc = 32'h0;
      m_mis = 0; m_hlt = 0; m_req = 0; m_iv = 0;
      return;
    end
    case (m_ph)
      PF: begin
        if (m_req && bus.imem_ready) begin
          m_ph = PE; m_req = 0; m_iv = 1;
        end else begin
          m_req = 1; m_iv = 0;
        end
      end
      PE: begin
        m_iv = 0; m_req = 0;
        if (bus.commit && !bus.stall) begin
          redir = bus.jr | bus.jump | bus.branch_taken;
          if (bus.jr) nxt = bus.jr_target;
          else if (bus.jump) nxt = bus.jump_target;
          else if (bus.branch_taken) nxt = bus.branch_target;
          else nxt = m_pc + 32'd4;
          if (bus.exception) begin
            m_epc = m_pc; m_pc = EXCV; m_mis = 0;
            m_ph = PF; m_req = 1;
          end else if (bus.halt) begin
            m_ph = PH; m_hlt = 1;
          end else begin
            m_ph = PF; m_req = 1;
            if (redir && (nxt % 4) != 0) begin
              m_epc = m_pc; m_pc = EXCV; m_mis = 1;
            end else begin
              m_pc = nxt;
            end
          end
        end
      end
      default: begin
        m_iv = 0; m_req = 0;
      end
    endcase
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(
    input string name,
    input logic [31:0] pc, input logic req,
    input logic iv, input logic [31:0] epc,
    input logic mis, input logic hlt);
    tests++;
    if (bus.pc_out !== pc || bus.imem_req !== req ||
        bus.instr_valid !== iv || bus.epc !== epc ||
        bus.misalign !== mis || bus.halted !== hlt) begin
      fails++;
      $display("FAIL %s: got pc=%h req=%b iv=%b epc=%h mis=%b hlt=%b want pc=%h req=%b iv=%b epc=%h mis=%b hlt=%b",
        name, bus.pc_out, bus.imem_req, bus.instr_valid,
        bus.epc, bus.misalign, bus.halted,
        pc, req, iv, epc, mis, hlt);
    end
  endtask

  initial begin
    logic [31:0] t;
    drive(0, 0, 0, 0, 5'b0, 32'h0);
    bus.jump_target = 32'h100;
    bus.jr_target   = 32'h200;
    m_ph = PF; m_pc = 0; m_epc = 0;
    m_mis = 0; m_hlt = 0; m_req = 0; m_iv = 0;

    add(0,1,0,0,0,0,       0,0,0,0,0,0);
    add(0,1,0,0,0,0,       0,0,0,0,0,0);
    add(1,1,0,0,0,0,       0,1,0,0,0,0);
    add(1,1,0,0,0,0,       0,0,1,0,0,0);
    add(1,1,1,0,0,0,       4,1,0,0,0,0);
    add(1,1,0,0,0,0,       4,0,1,0,0,0);
    add(1,1,1,0,0,0,       8,1,0,0,0,0);
    for (int i = 0; i < 5; i++)
      add(1,0,0,0,0,0,     8,1,0,0,0,0);
    add(1,1,0,0,0,0,       8,0,1,0,0,0);
    add(1,1,1,0,0,0,   'h0c,1,0,0,0,0);
    add(1,1,0,0,0,0,   'h0c,0,1,0,0,0);
    add(1,1,1,0,0,0,   'h10,1,0,0,0,0);
    add(1,1,0,0,0,0,   'h10,0,1,0,0,0);
    add(1,1,1,0,C_JR|C_JMP|C_BR,'h40,
                      'h200,1,0,0,0,0);
    add(1,1,0,0,0,0,  'h200,0,1,0,0,0);
    add(1,1,1,0,C_JMP|C_BR,'h40,
                      'h100,1,0,0,0,0);
    add(1,1,0,0,0,0,  'h100,0,1,0,0,0);
    add(1,1,1,0,C_BR,'h20,
                       'h20,1,0,0,0,0);
    add(1,1,0,0,0,0,   'h20,0,1,0,0,0);
    add(1,1,1,0,C_EXC|C_JR,0,
                       EXCV,1,0,'h20,0,0);
    add(1,1,0,0,0,0,   EXCV,0,1,'h20,0,0);
    add(1,1,1,0,C_BR,'h24,
                       'h24,1,0,'h20,0,0);
    add(1,1,0,0,0,0,   'h24,0,1,'h20,0,0);
    add(1,1,1,0,C_BR,'h42,
                       EXCV,1,0,'h24,1,0);
    add(1,1,0,0,0,0,   EXCV,0,1,'h24,1,0);
    add(1,1,1,0,C_BR,'h30,
                       'h30,1,0,'h24,1,0);
    add(1,1,0,0,0,0,   'h30,0,1,'h24,1,0);
    for (int i = 0; i < 3; i++)
      add(1,1,1,1,C_BR,'h44,
                       'h30,0,0,'h24,1,0);
    add(1,1,1,0,0,0,   'h34,1,0,'h24,1,0);
    add(1,1,0,0,0,0,   'h34,0,1,'h24,1,0);
    add(1,1,1,0,C_BR,'h50,
                       'h50,1,0,'h24,1,0);
    add(1,1,0,0,0,0,   'h50,0,1,'h24,1,0);
    add(1,1,1,0,C_HLT,0,
                       'h50,0,0,'h24,1,1);
    for (int i = 0; i < 10; i++)
      add(1,1,logic'(i % 2),0,C_JR,0,
                       'h50,0,0,'h24,1,1);
    add(0,1,1,0,0,0,       0,0,0,0,0,0);
    add(1,0,0,0,0,0,       0,1,0,0,0,0);
    add(1,0,0,0,0,0,       0,1,0,0,0,0);
    add(0,1,0,0,0,0,       0,0,0,0,0,0);
    add(1,1,0,0,0,0,       0,1,0,0,0,0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rdy, tbl[i].cmt,
            tbl[i].stl, tbl[i].ctl, tbl[i].bt);
      step();
      check($sformatf("vec%0d", i), tbl[i].pc,
            tbl[i].req, tbl[i].iv, tbl[i].epc,
            tbl[i].mis, tbl[i].hlt);
    end

    // PC wrap at the top of the address space
    bus.jr_target = 32'hFFFF_FFFC;
    drive(1,1,0,0,0,0); step();
    check("wrap_fetch", 0, 0, 1, 0, 0, 0);
    drive(1,1,1,0,C_JR,0); step();
    check("wrap_jr", 32'hFFFF_FFFC, 1, 0, 0, 0, 0);
    drive(1,1,0,0,0,0); step();
    check("wrap_exec", 32'hFFFF_FFFC, 0, 1, 0, 0, 0);
    drive(1,1,1,0,0,0); step();
    check("wrap_seq", 0, 1, 0, 0, 0, 0);

    // exception outranks halt
    drive(1,1,0,0,0,0); step();
    drive(1,1,1,0,C_EXC|C_HLT,0); step();
    check("exc_over_halt", EXCV, 1, 0, 0, 0, 0);

    drive(0,0,0,0,0,0); step();
    check("rand_reset", m_pc, m_req, m_iv,
          m_epc, m_mis, m_hlt);
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(49) != 0);
      bus.imem_ready   = ($urandom_range(9) < 6);
      bus.commit       = ($urandom_range(1) == 1);
      bus.stall        = ($urandom_range(3) == 0);
      bus.exception    = ($urandom_range(9) == 0);
      bus.halt         = ($urandom_range(19) == 0);
      bus.jr           = ($urandom_range(3) == 0);
      bus.jump         = ($urandom_range(3) == 0);
      bus.branch_taken = ($urandom_range(3) == 0);
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      bus.branch_target = t;
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      bus.jump_target = t;
      t = $urandom;
      if ($urandom_range(3) != 0) t[1:0] = 2'b00;
      bus.jr_target = t;
      step();
      check($sformatf("rand%0d", i), m_pc, m_req,
            m_iv, m_epc, m_mis, m_hlt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
